// File: rtl/alu_pipe_pkg.sv
// Shared opcode/state definitions for the alu_pipe execute stage.
// ALU_PIPE_MUL_EN widens the legal opcode set to include OP_MUL.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_REMU;
`endif
  endfunction

endpackage

// File: rtl/alu_pipe_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// The start cycle already resolves the MSB so a full divide spans XLEN edges.
module alu_pipe_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dsr;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic [XLEN-1:0] w_src_rem;
  logic [XLEN-1:0] w_src_quo;
  logic [XLEN-1:0] w_src_dsr;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  always_comb begin
    w_src_rem = i_start ? '0 : r_rem;
    w_src_quo = i_start ? i_dividend : r_quo;
    w_src_dsr = i_start ? i_divisor : r_dsr;
    w_sh      = {w_src_rem, w_src_quo[XLEN-1]};
    w_diff    = w_sh - {1'b0, w_src_dsr};
    w_ge      = !w_diff[XLEN];
    w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
    w_quo_nxt = {w_src_quo[XLEN-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dsr  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      r_dsr  <= i_divisor;
      r_cnt  <= CW'(XLEN - 2);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

  // High during the cycle that resolves bit 0; results are final the cycle after.
  assign o_done      = r_busy && (r_cnt == '0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake and iterative divider.
// Define ALU_PIPE_MUL_EN to add the two-stage OP_MUL path.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int SHW = $clog2(XLEN);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_err;
  logic [TAG_W-1:0] r_div_tag;
  logic             r_div_rem;

  logic             w_out_free;
  logic             w_accept;
  logic             w_is_div_op;
  logic             w_div_start;
  logic             w_div_done;
  logic [XLEN-1:0]  w_div_quo;
  logic [XLEN-1:0]  w_div_rem;
  logic             w_mul_busy;
  logic             w_mul_start;
  logic [SHW-1:0]   w_shamt;
  logic [XLEN-1:0]  w_alu_res;
  logic             w_alu_err;
  logic             w_load;
  logic [XLEN-1:0]  w_load_res;
  logic [TAG_W-1:0] w_load_tag;
  logic             w_load_err;

`ifdef ALU_PIPE_MUL_EN
  logic             r_mul_v;
  logic [XLEN-1:0]  r_mul_p;
  logic [TAG_W-1:0] r_mul_tag;
  assign w_mul_busy  = r_mul_v;
  assign w_mul_start = w_accept && (in_op == OP_MUL);
`else
  assign w_mul_busy  = 1'b0;
  assign w_mul_start = 1'b0;
`endif

  assign w_out_free  = !r_out_valid || out_ready;
  assign in_ready    = rst_n && !flush && (r_state == S_IDLE) && !w_mul_busy && w_out_free;
  assign w_accept    = in_valid && in_ready;
  assign w_is_div_op = (in_op == OP_DIVU) || (in_op == OP_REMU);
  assign w_div_start = w_accept && w_is_div_op && (in_b != '0);
  assign w_shamt     = in_b[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_err = !is_legal_op(in_op) || (w_is_div_op && (in_b == '0));
    case (in_op)
      OP_ADD:  w_alu_res = in_a + in_b;
      OP_SUB:  w_alu_res = in_a - in_b;
      OP_AND:  w_alu_res = in_a & in_b;
      OP_OR:   w_alu_res = in_a | in_b;
      OP_XOR:  w_alu_res = in_a ^ in_b;
      OP_SLL:  w_alu_res = in_a << w_shamt;
      OP_SRL:  w_alu_res = in_a >> w_shamt;
      OP_SRA:  w_alu_res = $signed(in_a) >>> w_shamt;
      OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      OP_DIVU: w_alu_res = '1;
      OP_REMU: w_alu_res = in_a;
      default: w_alu_res = '0;
    endcase
  end

  // Sources of an output-register write are mutually exclusive: accepts only happen in IDLE with no MUL in flight.
  always_comb begin
    w_load     = 1'b0;
    w_load_res = w_alu_res;
    w_load_tag = in_tag;
    w_load_err = w_alu_err;
    if ((r_state == S_DONE) && w_out_free) begin
      w_load     = 1'b1;
      w_load_res = r_div_rem ? w_div_rem : w_div_quo;
      w_load_tag = r_div_tag;
      w_load_err = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    end else if (r_mul_v && w_out_free) begin
      w_load     = 1'b1;
      w_load_res = r_mul_p;
      w_load_tag = r_mul_tag;
      w_load_err = 1'b0;
`endif
    end else if (w_accept && !w_div_start && !w_mul_start) begin
      w_load = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_state_nxt = S_DIV;
      S_DIV:   if (w_div_done) w_state_nxt = S_DONE;
      S_DONE:  if (w_out_free) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_err    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_load_res;
      r_out_tag    <= w_load_tag;
      r_out_err    <= w_load_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_tag <= '0;
      r_div_rem <= 1'b0;
    end else if (w_div_start) begin
      r_div_tag <= in_tag;
      r_div_rem <= (in_op == OP_REMU);
    end
  end

`ifdef ALU_PIPE_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_v   <= 1'b0;
      r_mul_p   <= '0;
      r_mul_tag <= '0;
    end else if (flush) begin
      r_mul_v <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_v   <= 1'b1;
      r_mul_p   <= in_a * in_b;
      r_mul_tag <= in_tag;
    end else if (r_mul_v && w_out_free) begin
      r_mul_v <= 1'b0;
    end
  end
`endif

  // A flushed divide keeps running internally; its done pulse lands in IDLE and is ignored.
  alu_pipe_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_dividend  (in_a),
    .i_divisor   (in_b),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: randomized and directed ops vs. an arithmetic reference model.
module tb_alu_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  bit          rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
    exp_t       e;
    logic [4:0] sh;
    sh    = b[4:0];
    e.res = '0;
    e.tag = tag;
    e.err = 1'b0;
    e.acc = 0;
    e.lat = 1;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a << sh;
      4'd6:  e.res = a >> sh;
      4'd7:  e.res = 32'($signed(a) >>> sh);
      4'd8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.err = 1'b1; end
             else begin e.res = a / b; e.lat = XLEN + 1; end
      4'd11: if (b == 0) begin e.res = a; e.err = 1'b1; end
             else begin e.res = a % b; e.lat = XLEN + 1; end
`ifdef ALU_PIPE_MUL_EN
      4'd12: begin e.res = a * b; e.lat = 2; end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: pops one expectation per output handshake, checks value, tag, err, latency and hold-stability.
  bit          seen = 0;
  int unsigned seen_cyc = 0;
  logic [37:0] snap;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      seen = 0;
    end else begin
      if (!seen) begin
        seen     = 1;
        seen_cyc = cyc;
        snap     = {out_result, out_tag, out_err};
      end else begin
        check("hold_stable", {26'd0, out_result, out_tag, out_err}, {26'd0, snap});
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result", {32'd0, out_result}, {32'd0, mon_e.res});
          check("tag", {59'd0, out_tag}, {59'd0, mon_e.tag});
          check("err", {63'd0, out_err}, {63'd0, mon_e.err});
          check("latency", 64'(seen_cyc - mon_e.acc), 64'(mon_e.lat));
        end
        seen = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int unsigned acc);
    exp_t e;
    bit   done = 0;
    acc      = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(op, a, b, tag);
        e.acc = cyc;
        acc   = cyc;
        sb.push_back(e);
        done  = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic wait_empty();
    bit done = 0;
    rnd_ready = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
      tick();
    end
    if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  int unsigned acc;
  int unsigned t0;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_result", {32'd0, out_result}, 64'd0);
    check("reset_out_tag", {59'd0, out_tag}, 64'd0);
    check("reset_out_err", {63'd0, out_err}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3, acc);
    issue(4'd7, 32'h8000_0000, 32'h24, 5'd4, acc);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd5, acc);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd6, acc);
    wait_empty();

    issue(4'd10, 32'd100, 32'd7, 5'd1, acc);
    for (int i = 0; i < XLEN; i++) begin
      @(negedge clk);
      check("div_in_ready_low", {63'd0, in_ready}, 64'd0);
      tick();
    end
    wait_empty();
    issue(4'd11, 32'd100, 32'd7, 5'd2, acc);
    wait_empty();
    issue(4'd10, 32'd5, 32'd0, 5'd7, acc);
    issue(4'd11, 32'd5, 32'd0, 5'd8, acc);
    wait_empty();

    out_ready = 1'b0;
    issue(4'd0, 32'd10, 32'd20, 5'd4, acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_out_result", {32'd0, out_result}, 64'd30);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    t0 = cyc;
    issue(4'd1, 32'd50, 32'd8, 5'd5, acc);
    check("b2b_accept_cycle", 64'(acc), 64'(t0));
    wait_empty();

    issue(4'd10, 32'd1000, 32'd3, 5'd9, acc);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    for (int i = 0; i < 2 * XLEN; i++) begin
      @(negedge clk);
      check("flush_no_valid", {63'd0, out_valid}, 64'd0);
      tick();
    end

    issue(4'd13, 32'd1, 32'd2, 5'd10, acc);
    issue(4'd12, 32'h0001_0003, 32'h0002_0005, 5'd11, acc);
    wait_empty();

    rnd_ready = 1;
    for (int k = 0; k < 300; k++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      if ($urandom_range(0, 7) == 0)      r_b = '0;
      else if ($urandom_range(0, 1) == 0) r_b = $urandom;
      else                                r_b = $urandom_range(1, 300);
      issue(r_op, r_a, r_b, 5'($urandom), acc);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered execute-stage ALU; successor to the purely combinational single-control ALU.
- Adds a full op set, a valid/ready handshake, an output register with backpressure, and an iterative unsigned divider that stalls the issue side.
- Sits between decode/issue and writeback in the pipelined core.
- Passes a tag through so the writeback stage can route results.

Parameters:
- XLEN, 32, operand/result width; must be >= 8.
- TAG_W, 5, width of the passthrough tag (destination register index).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of in-flight op and output register
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_op  in  4  opcode (alu_pipe_pkg encoding)
- in_a  in  XLEN  operand A / dividend
- in_b  in  XLEN  operand B / divisor / shift amount
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of result
- out_err  out  1  illegal opcode, or divide by zero

Behaviour:
- Reset values: out_valid=0, out_result=0, out_tag=0, out_err=0, FSM=IDLE, divider registers=0. in_ready is 0 while rst_n is low.
- Opcode encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = in_b[$clog2(XLEN)-1:0].
  - 8 SLT (signed), 9 SLTU; result 1 or 0, zero-extended.
  - 10 DIVU, 11 REMU.
  - 12 MUL (optional feature only).
  - Any other value: illegal; result 0, out_err=1, latency 1.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- FSM states: IDLE, DIV, DONE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Output therefore drains in the same cycle as the next accept.
- Single-cycle ops, accepted at cycle N: out_valid=1 from N+1, holding result and tag until the handshake completes.
- DIVU/REMU, in_b != 0:
  - On accept, latch operands and tag; IDLE->DIV.
  - Restoring shift-subtract, one quotient bit per cycle, for XLEN cycles; counter runs from XLEN-1 down to 0.
  - DIV->DONE after the last bit.
  - In DONE, write the quotient (DIVU) or remainder (REMU) into the output register once out_valid=0 or out_ready=1; DONE->IDLE.
  - Minimum latency: accept at N -> out_valid at N+XLEN+1.
- DIVU/REMU, in_b == 0: no iteration, latency 1, out_err=1.
  - DIVU result = all-ones.
  - REMU result = in_a.
- out_valid && !out_ready: output register, tag and err hold stable; DONE waits.
- flush: next edge forces FSM=IDLE and out_valid=0. An op offered in the same cycle as flush is not accepted.
- Flush has priority over every other event, including a completion in the same cycle.
- Reset mid-division: abandon immediately and return to reset values.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- With the macro defined:
  - opcode 12 = MUL, low XLEN bits of the unsigned product.
  - Two-stage pipelined multiply, latency 2; issue blocked (in_ready=0) during the second cycle.
  - Otherwise obeys the same output-register rules as other ops.
- Without the macro: opcode 12 is illegal (result 0, out_err=1, latency 1). No multiplier logic is synthesised.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode localparams/enum (OP_ADD..OP_MUL);
  - FSM state enum;
  - is_legal_op function.
- Sub-module alu_pipe_div: iterative unsigned divider.
  - Inputs: start, dividend, divisor.
  - Outputs: done pulse, quotient, remainder.
  - Clock and reset are the same as the parent's.
- Single-cycle ops stay in the parent as a combinational case.

Test Plan:
- Reset then ADD a=0xFFFFFFFF, b=1, tag=3 -> out_valid one cycle after accept; result 0x00000000, tag 3, err 0.
- SRA a=0x80000000, b=0x24 (shift 4) -> 0xF8000000. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU same operands -> 0.
- DIVU a=100, b=7, out_ready=1:
  - in_ready low for the whole operation;
  - out_valid at accept+33, result 14;
  - REMU with the same operands -> 2.
- DIVU a=5, b=0 -> result 0xFFFFFFFF, err 1, latency 1. REMU a=5, b=0 -> 5, err 1.
- out_ready held 0 for 5 cycles after an ADD result -> result stable and in_ready=0 throughout. Raise out_ready with a new in_valid -> drain and accept in the same cycle, back-to-back.
- flush asserted 10 cycles into a DIVU -> out_valid never rises, FSM returns to IDLE, in_ready=1 the next cycle. Opcode 13 -> err 1, result 0. Opcode 12 -> err 1 when the macro is undefined; product low bits at latency 2 when it is defined.
